w_beat_packer: RTL and testbench

Upstream feeder of the on-chip AXI write-data (W) channel. Accepts the compressor's 16-bit halfword output stream, one compressed block per command, and packs four halfwords per 64-bit W beat. It generates per-lane strobes, the burst id and last, and splits long blocks into bursts of at most MAX_BEATS beats. It emits a completion record per block for the write-address/bookkeeping logic.

---
 rtl/compressor_axi_pkg.sv | 25 ++
 rtl/w_beat_packer.sv | 114 +++++++++++
 tb/tb_w_beat_packer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/compressor_axi_pkg.sv
// Shared definitions for the compressor-to-AXI write path: channel widths,
// packer state encoding and the W beat payload used by drivers and monitors.
package compressor_axi_pkg;

   localparam int unsigned ID_W      = 4;
   localparam int unsigned DATA_W    = 64;
   localparam int unsigned STRB_W    = 4;
   localparam int unsigned LANE_W    = DATA_W / STRB_W;
   localparam int unsigned MAX_BEATS = 16;
   localparam int unsigned CNT_W     = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PACK = 2'd1,
      SEND = 2'd2
   } state_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
      logic              last;
   } w_beat_t;

endpackage

// File: rtl/w_beat_packer.sv
// Packs the compressor halfword stream into 64-bit AXI W beats, splitting
// blocks into bursts of at most MAX_BEATS and reporting per-block beat counts.
module w_beat_packer
   import compressor_axi_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ID_W-1:0]   cmd_id,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_data,
   input  logic              in_last,
   output logic [ID_W-1:0]   w_id,
   output logic [DATA_W-1:0] w_data,
   output logic [STRB_W-1:0] w_strb,
   output logic              w_last,
   output logic              w_valid,
   input  logic              w_ready,
   output logic              done_valid,
   output logic [CNT_W-1:0]  done_beats
);

   localparam int unsigned LANE_IDX_W = $clog2(STRB_W);
   localparam int unsigned BEAT_W     = $clog2(MAX_BEATS + 1);

   state_t                state;
   w_beat_t               beat_q;
   logic [LANE_IDX_W-1:0] lane;
   logic [BEAT_W-1:0]     beat_cnt;
   logic [CNT_W-1:0]      total_cnt;
   logic                  blk_end;
   logic [CNT_W-1:0]      total_inc_c;
   logic                  beat_full_c;
   logic                  burst_full_c;

   assign cmd_ready = (state == IDLE);
   assign in_ready  = (state == PACK);

   assign w_id   = beat_q.id;
   assign w_data = beat_q.data;
   assign w_strb = beat_q.strb;
   assign w_last = beat_q.last;

   // Block beat count sticks at all-ones rather than wrapping.
   assign total_inc_c  = (&total_cnt) ? total_cnt : total_cnt + 1'b1;
   assign beat_full_c  = (lane == LANE_IDX_W'(STRB_W - 1));
   assign burst_full_c = (beat_cnt == BEAT_W'(MAX_BEATS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         beat_q     <= '0;
         lane       <= '0;
         beat_cnt   <= '0;
         total_cnt  <= '0;
         blk_end    <= 1'b0;
         w_valid    <= 1'b0;
         done_valid <= 1'b0;
         done_beats <= '0;
      end else begin
         done_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  beat_q.id   <= cmd_id;
                  beat_q.data <= '0;
                  beat_q.strb <= '0;
                  lane        <= '0;
                  beat_cnt    <= '0;
                  total_cnt   <= '0;
                  state       <= PACK;
               end
            end
            PACK: begin
               if (in_valid && in_ready) begin
                  beat_q.data[LANE_W*lane +: LANE_W] <= in_data;
                  beat_q.strb[lane]                  <= 1'b1;
                  lane                               <= lane + 1'b1;
                  if (beat_full_c || in_last) begin
                     // Burst boundary and block end can coincide; last is raised once.
                     beat_q.last <= in_last || burst_full_c;
                     blk_end     <= in_last;
                     w_valid     <= 1'b1;
                     state       <= SEND;
                  end
               end
            end
            SEND: begin
               if (w_valid && w_ready) begin
                  w_valid     <= 1'b0;
                  beat_q.last <= 1'b0;
                  beat_q.data <= '0;
                  beat_q.strb <= '0;
                  lane        <= '0;
                  total_cnt   <= total_inc_c;
                  beat_cnt    <= beat_q.last ? '0 : beat_cnt + 1'b1;
                  if (blk_end) begin
                     done_valid <= 1'b1;
                     done_beats <= total_inc_c;
                     blk_end    <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     state <= PACK;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_w_beat_packer.sv
// Scoreboard bench for w_beat_packer: a block model queues expected W beats
// and done counts, monitors pop and compare them on each handshake.
module tb_w_beat_packer;
   import compressor_axi_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ID_W-1:0]   cmd_id;
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       in_data;
   logic              in_last;
   logic [ID_W-1:0]   w_id;
   logic [DATA_W-1:0] w_data;
   logic [STRB_W-1:0] w_strb;
   logic              w_last;
   logic              w_valid;
   logic              w_ready;
   logic              done_valid;
   logic [CNT_W-1:0]  done_beats;

   w_beat_packer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_id     (cmd_id),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .w_id       (w_id),
      .w_data     (w_data),
      .w_strb     (w_strb),
      .w_last     (w_last),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .done_valid (done_valid),
      .done_beats (done_beats)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   w_beat_t     exp_q[$];
   int unsigned done_q[$];
   logic [15:0] hw_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: four halfwords per beat, lane 0 first, last every MAX_BEATS and at block end.
   task automatic push_model(input logic [ID_W-1:0] id);
      int n  = hw_q.size();
      int nb = (n + 3) / 4;
      for (int b = 0; b < nb; b++) begin
         w_beat_t e;
         e    = '0;
         e.id = id;
         for (int l = 0; l < 4; l++) begin
            if (4*b + l < n) begin
               e.data[16*l +: 16] = hw_q[4*b + l];
               e.strb[l]          = 1'b1;
            end
         end
         e.last = (b == nb - 1) || (((b + 1) % MAX_BEATS) == 0);
         exp_q.push_back(e);
      end
      done_q.push_back(nb);
   endtask

   // Drives one block; cmd and first halfword are raised together. abort_n>0 resets mid-block.
   task automatic send_block(input logic [ID_W-1:0] id, input int abort_n);
      int n     = hw_q.size();
      int i     = 0;
      int guard = 0;
      bit cacc;
      bit hacc;
      if (abort_n == 0) push_model(id);
      cmd_id    = id;
      cmd_valid = 1'b1;
      in_valid  = 1'b1;
      in_data   = hw_q[0];
      in_last   = (n == 1);
      while (i < n && guard < 2000) begin
         @(negedge clk);
         cacc = cmd_valid && cmd_ready;
         hacc = in_valid && in_ready;
         @(posedge clk);
         #1;
         guard++;
         if (cacc) cmd_valid = 1'b0;
         if (hacc) begin
            i++;
            if (i < n) begin
               in_data = hw_q[i];
               in_last = (i == n - 1);
            end else begin
               in_valid = 1'b0;
               in_last  = 1'b0;
            end
         end
         if (abort_n > 0 && i == abort_n) begin
            chk("pre_rst_strb", w_strb, 4'b0011);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_w_valid", w_valid, 0);
            chk("rst_w_strb", w_strb, 0);
            chk("rst_w_data", w_data, 0);
            cmd_valid = 1'b0;
            in_valid  = 1'b0;
            in_last   = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            chk("rel_cmd_ready", cmd_ready, 1);
            chk("rel_in_ready", in_ready, 0);
            return;
         end
      end
      if (guard >= 2000) chk("drv_timeout", 1, 0);
   endtask

   // Holds w_ready low for 10 cycles once the first beat is presented.
   task automatic stall_watch();
      int      g = 0;
      w_beat_t s;
      while (g < 200) begin
         @(negedge clk);
         if (w_valid) break;
         g++;
      end
      if (g >= 200) chk("stall_timeout", 1, 0);
      s.id = w_id; s.data = w_data; s.strb = w_strb; s.last = w_last;
      repeat (10) begin
         @(negedge clk);
         chk("stall_valid", w_valid, 1);
         chk("stall_data", w_data, s.data);
         chk("stall_strb", w_strb, s.strb);
         chk("stall_id", w_id, s.id);
         chk("stall_last", w_last, s.last);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_cmd_ready", cmd_ready, 0);
      end
      @(posedge clk);
      #1 w_ready = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst_n && w_valid && w_ready) begin
         if (exp_q.size() == 0) chk("w_extra", 1, 0);
         else begin
            w_beat_t e;
            e = exp_q.pop_front();
            chk("w_id", w_id, e.id);
            chk("w_data", w_data, e.data);
            chk("w_strb", w_strb, e.strb);
            chk("w_last", w_last, e.last);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done_valid) begin
         if (done_q.size() == 0) chk("done_extra", 1, 0);
         else chk("done_beats", done_beats, done_q.pop_front());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_id    = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      w_ready   = 1'b1;
      #12;
      chk("rst_w_valid0", w_valid, 0);
      chk("rst_w_last0", w_last, 0);
      chk("rst_w_data0", w_data, 0);
      chk("rst_w_strb0", w_strb, 0);
      chk("rst_w_id0", w_id, 0);
      chk("rst_done_valid0", done_valid, 0);
      chk("rst_done_beats0", done_beats, 0);
      chk("rst_cmd_ready0", cmd_ready, 1);
      chk("rst_in_ready0", in_ready, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      hw_q.delete();
      for (int k = 1; k <= 8; k++) hw_q.push_back(16'(k));
      send_block(4'h5, 0);

      hw_q.delete();
      for (int k = 1; k <= 5; k++) hw_q.push_back(16'(16'hA0A0 + k));
      send_block(4'h6, 0);

      hw_q.delete();
      for (int k = 0; k < 68; k++) hw_q.push_back(16'($urandom));
      send_block(4'h9, 0);

      hw_q.delete();
      for (int k = 0; k < 64; k++) hw_q.push_back(16'($urandom));
      send_block(4'hC, 0);

      hw_q.delete();
      for (int k = 0; k < 4; k++) hw_q.push_back(16'(16'hB000 + k));
      @(posedge clk);
      #1 w_ready = 1'b0;
      fork
         send_block(4'h3, 0);
         stall_watch();
      join

      g = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && g < 100) begin
         @(negedge clk);
         g++;
      end
      @(posedge clk);
      #1;
      hw_q.delete();
      for (int k = 0; k < 4; k++) hw_q.push_back(16'(16'hDEA0 + k));
      send_block(4'h7, 2);

      hw_q.delete();
      hw_q.push_back(16'h1234);
      send_block(4'hA, 0);

      hw_q.delete();
      for (int k = 0; k < 7; k++) hw_q.push_back(16'(16'h7700 + k));
      send_block(4'h2, 0);

      g = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && g < 500) begin
         @(negedge clk);
         g++;
      end
      repeat (5) @(negedge clk);
      chk("exp_left", 64'(exp_q.size()), 0);
      chk("done_left", 64'(done_q.size()), 0);
      chk("end_w_valid", w_valid, 0);
      chk("end_cmd_ready", cmd_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
